// File: rtl/memory_controller.sv
// Shares the byte-wide RAM/IO port between instruction fetch and the load/store buffer.
// Round-robin arbitration, one access in flight, multi-byte accesses split into byte cycles.
module memory_controller #(
  parameter logic [1:0] IO_SEL   = 2'b11,
  parameter bit         IF_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_valid,
  input  logic        lsb_ls,
  input  logic [5:0]  lsb_opcode,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_s_data,
  output logic        lsb_done,
  output logic [31:0] lsb_l_data
);

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] lsb_l_data_q, lsb_l_data_d;
  logic        rr_if_q, rr_if_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [2:0]  len_q, len_d;
  logic [5:0]  op_q, op_d;
  logic        src_if_q, src_if_d;

  logic        grant_if, grant_lsb;
  logic [31:0] nbuf;
  logic [1:0]  bidx;
  logic [2:0]  nxt;
  logic [31:0] nxt_addr;

  function automatic logic [2:0] width_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: width_of = 3'd1;
      OP_LH, OP_LHU, OP_SH: width_of = 3'd2;
      default:              width_of = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] w);
    case (op)
      OP_LB:   extend = {{24{w[7]}}, w[7:0]};
      OP_LH:   extend = {{16{w[15]}}, w[15:0]};
      OP_LBU:  extend = {24'd0, w[7:0]};
      OP_LHU:  extend = {16'd0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    byte_of = w[7:0];
      2'd1:    byte_of = w[15:8];
      2'd2:    byte_of = w[23:16];
      default: byte_of = w[31:24];
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] a);
    is_io = (a[17:16] == IO_SEL);
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    if_done_d    = 1'b0;
    lsb_done_d   = 1'b0;
    if_data_d    = if_data_q;
    lsb_l_data_d = lsb_l_data_q;
    rr_if_d      = rr_if_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    rbuf_d       = rbuf_q;
    len_d        = len_q;
    op_d         = op_q;
    src_if_d     = src_if_q;
    grant_if     = 1'b0;
    grant_lsb    = 1'b0;
    bidx         = cnt_q[1:0] - 2'd2;
    nbuf         = rbuf_q;
    nbuf[{bidx, 3'b000} +: 8] = mem_din;
    nxt          = cnt_q + 3'd1;
    nxt_addr     = addr_q + {29'd0, nxt};

    case (state_q)
      IDLE: begin
        // A done pulse this cycle forces one turnaround cycle before the next grant.
        if (!if_done_q && !lsb_done_q && !flush) begin
          grant_if  = if_valid && (!lsb_valid || rr_if_q);
          grant_lsb = lsb_valid && (!if_valid || !rr_if_q);
          if (grant_if) begin
            src_if_d = 1'b1;
            addr_d   = if_addr;
            len_d    = 3'd4;
            op_d     = OP_LW;
            rr_if_d  = 1'b0;
            rbuf_d   = '0;
            cnt_d    = 3'd1;
            mem_a_d  = if_addr;
            mem_wr_d = 1'b0;
            state_d  = READ;
          end else if (grant_lsb) begin
            src_if_d = 1'b0;
            addr_d   = lsb_addr;
            len_d    = width_of(lsb_opcode);
            op_d     = lsb_opcode;
            sdata_d  = lsb_s_data;
            rr_if_d  = 1'b1;
            rbuf_d   = '0;
            mem_a_d  = lsb_addr;
            if (lsb_ls) begin
              cnt_d    = 3'd1;
              mem_wr_d = 1'b0;
              state_d  = READ;
            end else begin
              cnt_d      = 3'd0;
              mem_dout_d = lsb_s_data[7:0];
              mem_wr_d   = !(is_io(lsb_addr) && io_buffer_full);
              state_d    = WRITE;
            end
          end
        end
      end
      READ: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          // cnt_q is the cycle index within the access; byte cnt_q-2 arrives now.
          if (cnt_q >= 3'd2) rbuf_d = nbuf;
          if (cnt_q < len_q) mem_a_d = addr_q + {29'd0, cnt_q};
          cnt_d = nxt;
          if (cnt_q == len_q + 3'd1) begin
            state_d = IDLE;
            if (src_if_q) begin
              if_data_d = nbuf;
              if_done_d = 1'b1;
            end else begin
              lsb_l_data_d = extend(op_q, nbuf);
              lsb_done_d   = 1'b1;
            end
          end
        end
      end
      WRITE: begin
        // Stores are committed: flush is ignored here. cnt_q is the byte on the bus.
        if (mem_wr_q) begin
          if (cnt_q == len_q - 3'd1) begin
            mem_wr_d   = 1'b0;
            lsb_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            cnt_d      = nxt;
            mem_a_d    = nxt_addr;
            mem_dout_d = byte_of(sdata_q, nxt[1:0]);
            mem_wr_d   = !(is_io(nxt_addr) && io_buffer_full);
          end
        end else begin
          mem_wr_d = !(is_io(mem_a_q) && io_buffer_full);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      if_data_q    <= '0;
      lsb_l_data_q <= '0;
      rr_if_q      <= IF_FIRST;
    end else if (rdy) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      if_done_q    <= if_done_d;
      lsb_done_q   <= lsb_done_d;
      if_data_q    <= if_data_d;
      lsb_l_data_q <= lsb_l_data_d;
      rr_if_q      <= rr_if_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      rbuf_q   <= rbuf_d;
      len_q    <= len_d;
      op_q     <= op_d;
      src_if_q <= src_if_d;
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q & rdy;
  assign if_done    = if_done_q;
  assign if_data    = if_data_q;
  assign lsb_done   = lsb_done_q;
  assign lsb_l_data = lsb_l_data_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: byte-wide RAM with one-cycle read latency, hand-computed expectations.
module tb_memory_controller;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_valid, lsb_ls;
  logic [5:0]  lsb_opcode;
  logic [31:0] lsb_addr, lsb_s_data;
  logic        lsb_done;
  logic [31:0] lsb_l_data;

  logic [7:0]  ram [0:4095];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_din <= ram[mem_a[11:0]];

  memory_controller #(.IO_SEL(2'b11), .IF_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_valid(lsb_valid), .lsb_ls(lsb_ls), .lsb_opcode(lsb_opcode),
    .lsb_addr(lsb_addr), .lsb_s_data(lsb_s_data),
    .lsb_done(lsb_done), .lsb_l_data(lsb_l_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lsb_req(input logic ls, input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    lsb_valid  = 1'b1;
    lsb_ls     = ls;
    lsb_opcode = op;
    lsb_addr   = a;
    lsb_s_data = d;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h020] = 8'h80;
    ram[12'h200] = 8'h44; ram[12'h201] = 8'h33; ram[12'h202] = 8'h22; ram[12'h203] = 8'h11;

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_valid = 1'b0; if_addr = '0;
    lsb_valid = 1'b0; lsb_ls = 1'b0; lsb_opcode = '0; lsb_addr = '0; lsb_s_data = '0;
    step(); step();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
    chk("rst_dones", {30'd0, if_done, lsb_done}, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_lsb_l_data", lsb_l_data, 32'h0);
    rst = 1'b0;
    step();

    // 1: instruction fetch of 0x100
    if_valid = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) begin
        chk("if_mem_a", mem_a, 32'h100 + 32'(c - 1));
        chk("if_mem_wr", {31'd0, mem_wr}, 32'h0);
      end
      if (c < 6) chk("if_done_early", {31'd0, if_done}, 32'h0);
    end
    chk("if_done", {31'd0, if_done}, 32'h1);
    chk("if_data", if_data, 32'h00000513);
    if_valid = 1'b0;
    step();
    chk("if_done_pulse", {31'd0, if_done}, 32'h0);

    // 2: LB then LBU of 0x80 at 0x20
    lsb_req(1'b1, OP_LB, 32'h20, 32'h0);
    step(); chk("lb_mem_a", mem_a, 32'h20);
    step(); chk("lb_done_early", {31'd0, lsb_done}, 32'h0);
    step(); chk("lb_done", {31'd0, lsb_done}, 32'h1);
    chk("lb_data", lsb_l_data, 32'hFFFFFF80);
    lsb_valid = 1'b0;
    step();
    lsb_req(1'b1, OP_LBU, 32'h20, 32'h0);
    step(); step(); step();
    chk("lbu_done", {31'd0, lsb_done}, 32'h1);
    chk("lbu_data", lsb_l_data, 32'h00000080);
    lsb_valid = 1'b0;
    step();

    // 3: SW 0xDEADBEEF to 0x40
    lsb_req(1'b0, OP_SW, 32'h40, 32'hDEADBEEF);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("sw_mem_a", mem_a, 32'h40 + 32'(c - 1));
      chk("sw_mem_wr", {31'd0, mem_wr}, 32'h1);
      chk("sw_done_early", {31'd0, lsb_done}, 32'h0);
    end
    step();
    chk("sw_dout_last", {24'd0, mem_dout}, 32'hDE);
    chk("sw_done", {31'd0, lsb_done}, 32'h1);
    chk("sw_wr_off", {31'd0, mem_wr}, 32'h0);
    chk("sw_mem_a_hold", mem_a, 32'h43);
    lsb_valid = 1'b0;

    // 4: IF and LB requested together from reset, both held
    rst = 1'b1; step(); rst = 1'b0; step();
    if_valid = 1'b1; if_addr = 32'h100;
    lsb_req(1'b1, OP_LB, 32'h20, 32'h0);
    step(); chk("rr_first_if", mem_a, 32'h100);
    for (int c = 2; c <= 6; c++) step();
    chk("rr_if_done", {30'd0, if_done, lsb_done}, 32'h2);
    step(); chk("rr_turnaround", {30'd0, if_done, lsb_done}, 32'h0);
    step(); chk("rr_second_lsb", mem_a, 32'h20);
    step(); step();
    chk("rr_lsb_done", {30'd0, if_done, lsb_done}, 32'h1);
    chk("rr_lsb_data", lsb_l_data, 32'hFFFFFF80);
    lsb_valid = 1'b0;
    step(); step(); chk("rr_third_if", mem_a, 32'h100);
    for (int c = 2; c <= 6; c++) step();
    chk("rr_if_done2", {30'd0, if_done, lsb_done}, 32'h2);
    if_valid = 1'b0;
    step();

    // 5: SB to IO region with io_buffer_full high for three cycles
    lsb_req(1'b0, OP_SB, 32'h00030000, 32'h1234565A);
    io_buffer_full = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) io_buffer_full = 1'b0;
      chk("io_stall_wr", {31'd0, mem_wr}, 32'h0);
      chk("io_stall_a", mem_a, 32'h00030000);
    end
    step();
    chk("io_issue_wr", {31'd0, mem_wr}, 32'h1);
    chk("io_issue_dout", {24'd0, mem_dout}, 32'h5A);
    chk("io_done_early", {31'd0, lsb_done}, 32'h0);
    step();
    chk("io_done", {31'd0, lsb_done}, 32'h1);
    lsb_valid = 1'b0;
    step();

    // 6a: flush in cycle 2 of a fetch of 0x200, then an LB proves IDLE
    if_valid = 1'b1; if_addr = 32'h200;
    step(); step();
    flush = 1'b1; if_valid = 1'b0;
    step();
    flush = 1'b0;
    lsb_req(1'b1, OP_LB, 32'h20, 32'h0);
    step(); chk("flush_idle_next", mem_a, 32'h20);
    step(); chk("flush_no_if_done", {31'd0, if_done}, 32'h0);
    step();
    chk("flush_lb_done", {30'd0, if_done, lsb_done}, 32'h1);
    chk("flush_if_data_kept", if_data, 32'h00000513);
    lsb_valid = 1'b0;
    step();

    // 6b: flush during SH does not cancel the store
    lsb_req(1'b0, OP_SH, 32'h50, 32'h0000A1B2);
    step();
    flush = 1'b1;
    chk("sh_b0", {mem_a[23:0], mem_dout}, {24'h000050, 8'hB2});
    step();
    chk("sh_b1", {mem_a[23:0], mem_dout}, {24'h000051, 8'hA1});
    chk("sh_b1_wr", {31'd0, mem_wr}, 32'h1);
    step();
    flush = 1'b0;
    chk("sh_done", {31'd0, lsb_done}, 32'h1);
    lsb_valid = 1'b0;
    step();

    // 7: rdy low freezes a store and gates mem_wr
    lsb_req(1'b0, OP_SB, 32'h60, 32'h00000077);
    step();
    rdy = 1'b0;
    #1;
    chk("rdy_gate_wr", {31'd0, mem_wr}, 32'h0);
    step();
    chk("rdy_frozen", {mem_a[23:0], mem_dout}, {24'h000060, 8'h77});
    chk("rdy_no_done", {31'd0, lsb_done}, 32'h0);
    rdy = 1'b1;
    #1;
    chk("rdy_wr_back", {31'd0, mem_wr}, 32'h1);
    step();
    chk("rdy_done", {31'd0, lsb_done}, 32'h1);
    lsb_valid = 1'b0;
    step();

    // 8: reset in the middle of a fetch aborts it
    if_valid = 1'b1; if_addr = 32'h100;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; if_valid = 1'b0;
    chk("rst_mid_a", mem_a, 32'h0);
    chk("rst_mid_if_data", if_data, 32'h0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("rst_mid_no_done", {30'd0, if_done, lsb_done}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
